// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: memory byte-read port, decoder handshake and control inputs.
// The master modport is the fetch unit side; slave is the memory/decoder environment.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              run;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic [15:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  run, redirect, redirect_addr, mem_ack, mem_data, instr_ready,
    output mem_req, mem_addr, instr, instr_pc, instr_valid, pc
  );

  modport slave (
    output run, redirect, redirect_addr, mem_ack, mem_data, instr_ready,
    input  mem_req, mem_addr, instr, instr_pc, instr_valid, pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches 16-bit little-endian instructions as two byte reads and hands them to the
// decoder over a valid/ready handshake; owns the PC and supports branch redirect.
//
// state    | meaning
// IDLE     | stopped, no memory request
// FETCH_LO | requesting low byte at PC
// FETCH_HI | requesting high byte at PC
// HOLD     | instruction valid, waiting for decoder accept
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  instruction_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [15:0]       instr_q;
  logic              mem_req_q;
  logic              instr_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      // Redirect wins over everything, including a same-cycle ack or accept.
      pc_q          <= bus.redirect_addr;
      instr_valid_q <= 1'b0;
      mem_req_q     <= bus.run;
      state_q       <= bus.run ? FETCH_LO : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q   <= FETCH_LO;
            mem_req_q <= 1'b1;
          end
        end
        FETCH_LO: begin
          if (bus.mem_ack) begin
            instr_q[7:0] <= bus.mem_data;
            instr_pc_q   <= pc_q;
            pc_q         <= pc_q + ADDR_W'(1);
            state_q      <= FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (bus.mem_ack) begin
            instr_q[15:8] <= bus.mem_data;
            pc_q          <= pc_q + ADDR_W'(1);
            state_q       <= HOLD;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            mem_req_q     <= bus.run;
            state_q       <= bus.run ? FETCH_LO : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;

endmodule
